// File: rtl/mmio_responder_pkg.sv
// Shared types for the physical IO responder.
//   - Physical IO address path layout and the timer/serial offsets inside the
//     IO space.
//   - Request/response bundles, the 64-bit timer count type and the serial
//     byte width.
//   - decode_io(): classifies a physical address into the register it selects.
//     Anything that is not a naturally aligned hit in IO space is an error.
package mmio_responder_pkg;

    typedef struct packed {
        logic        isUncachable;
        logic        isIO;
        logic [19:0] addr;
    } PhyAddrPath;

    localparam logic [19:0] PHY_ADDR_MTIME_LO    = 20'h0_0000;
    localparam logic [19:0] PHY_ADDR_MTIME_HI    = 20'h0_0004;
    localparam logic [19:0] PHY_ADDR_MTIMECMP_LO = 20'h0_0008;
    localparam logic [19:0] PHY_ADDR_MTIMECMP_HI = 20'h0_000C;
    localparam logic [19:0] PHY_ADDR_SERIAL      = 20'h0_2000;

    localparam int unsigned SERIAL_BYTE = 8;

    typedef logic [63:0] TimerCount;

    typedef struct packed {
        logic        isWrite;
        PhyAddrPath  addr;
        logic [31:0] wdata;
    } IO_Request;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        error;
    } IO_Response;

    typedef enum logic [2:0] {
        SEL_MTIME_LO,
        SEL_MTIME_HI,
        SEL_MTIMECMP_LO,
        SEL_MTIMECMP_HI,
        SEL_SERIAL,
        SEL_ERR
    } io_sel_e;

    function automatic io_sel_e decode_io(input PhyAddrPath a);
        io_sel_e sel;
        if (!a.isIO || (a.addr[1:0] != 2'b00)) begin
            sel = SEL_ERR;
        end else begin
            case (a.addr)
                PHY_ADDR_MTIME_LO:    sel = SEL_MTIME_LO;
                PHY_ADDR_MTIME_HI:    sel = SEL_MTIME_HI;
                PHY_ADDR_MTIMECMP_LO: sel = SEL_MTIMECMP_LO;
                PHY_ADDR_MTIMECMP_HI: sel = SEL_MTIMECMP_HI;
                PHY_ADDR_SERIAL:      sel = SEL_SERIAL;
                default:              sel = SEL_ERR;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/mmio_responder_serial_fifo.sv
// io_serial_fifo: small synchronous FIFO carrying serial output bytes.
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   in_valid/in_ready write side; a byte is stored when both are high
//   in_data           byte to store
//   full              all DEPTH entries occupied
//   out_ready         sink consumes the head entry when not empty
//   out_data          head entry (valid when !empty)
//   empty             no entries held
// Storage is registered, so a byte written into an empty FIFO shows up at the
// head on the following cycle (no write-to-read bypass).
module io_serial_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             full,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             push, pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign out_data = mem_q[rd_ptr_q];

    always_comb begin
        push     = in_valid && in_ready;
        pop      = !empty && out_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry contents need no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: target-side endpoint for physical IO requests (isIO=1).
// Implements the 64-bit mtime/mtimecmp timer and a serial output byte port
// drained through io_serial_fifo.
//   clk, rst                       clock, synchronous active-high reset
//   ioReqValid/ioReqReady          request handshake; ready = !fifo full
//   ioReqIsWrite, ioReqAddr,
//   ioReqWriteData                 request payload (addr is PhyAddrPath)
//   ioRespValid/Data/Error         registered one-cycle response pulse
//   serialValid/Data/Ready         FIFO head towards the UART side
//   timerInterrupt                 registered (mtime >= mtimecmp)
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int unsigned SERIAL_FIFO_DEPTH = 4,
    parameter int unsigned TIMER_PRESCALE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ioReqValid,
    output logic        ioReqReady,
    input  logic        ioReqIsWrite,
    input  logic [21:0] ioReqAddr,
    input  logic [31:0] ioReqWriteData,
    output logic        ioRespValid,
    output logic [31:0] ioRespData,
    output logic        ioRespError,
    output logic        serialValid,
    output logic [7:0]  serialData,
    input  logic        serialReady,
    output logic        timerInterrupt
);

    localparam int unsigned PRESCALE_W = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;

    IO_Request  io_req;
    io_sel_e    sel;
    logic       accept;
    logic       tick;
    logic       fifo_push;
    logic       fifo_in_ready;
    logic       fifo_full;
    logic       fifo_empty;

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    TimerCount             mtime_q, mtime_d;
    TimerCount             mtimecmp_q, mtimecmp_d;
    IO_Response            resp_q, resp_d;
    logic                  irq_q, irq_d;

    assign ioReqReady     = !fifo_full;
    assign serialValid    = !fifo_empty;
    assign ioRespValid    = resp_q.valid;
    assign ioRespData     = resp_q.data;
    assign ioRespError    = resp_q.error;
    assign timerInterrupt = irq_q;

    always_comb begin
        io_req = '{isWrite: ioReqIsWrite, addr: PhyAddrPath'(ioReqAddr), wdata: ioReqWriteData};
        sel    = decode_io(io_req.addr);
        accept = ioReqValid && ioReqReady;

        tick    = (presc_q == PRESCALE_W'(TIMER_PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;

        mtime_d    = mtime_q + TimerCount'(tick);
        mtimecmp_d = mtimecmp_q;
        resp_d     = '0;
        fifo_push  = 1'b0;

        if (accept) begin
            resp_d.valid = 1'b1;
            if (sel == SEL_ERR) begin
                resp_d.error = 1'b1;
            end else if (io_req.isWrite) begin
                // A half write is built from the pre-increment value, which
                // also drops this cycle's tick.
                case (sel)
                    SEL_MTIME_LO:    mtime_d = {mtime_q[63:32], io_req.wdata};
                    SEL_MTIME_HI:    mtime_d = {io_req.wdata, mtime_q[31:0]};
                    SEL_MTIMECMP_LO: mtimecmp_d[31:0]  = io_req.wdata;
                    SEL_MTIMECMP_HI: mtimecmp_d[63:32] = io_req.wdata;
                    SEL_SERIAL:      fifo_push = fifo_in_ready;
                    default:         ;
                endcase
            end else begin
                case (sel)
                    SEL_MTIME_LO:    resp_d.data = mtime_q[31:0];
                    SEL_MTIME_HI:    resp_d.data = mtime_q[63:32];
                    SEL_MTIMECMP_LO: resp_d.data = mtimecmp_q[31:0];
                    SEL_MTIMECMP_HI: resp_d.data = mtimecmp_q[63:32];
                    default:         resp_d.data = '0;
                endcase
            end
        end

        irq_d = (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            resp_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            resp_q     <= resp_d;
            irq_q      <= irq_d;
        end
    end

    io_serial_fifo #(
        .DEPTH (SERIAL_FIFO_DEPTH),
        .WIDTH (SERIAL_BYTE)
    ) u_serial_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fifo_push),
        .in_ready  (fifo_in_ready),
        .in_data   (io_req.wdata[SERIAL_BYTE-1:0]),
        .full      (fifo_full),
        .out_ready (serialReady),
        .out_data  (serialData),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: a queue/arithmetic reference model checked every
// cycle, directed sequences with literal expectations, then random traffic.
module tb_mmio_responder;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned PRESCALE = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ioReqValid = 1'b0;
    logic        ioReqReady;
    logic        ioReqIsWrite = 1'b0;
    logic [21:0] ioReqAddr = '0;
    logic [31:0] ioReqWriteData = '0;
    logic        ioRespValid;
    logic [31:0] ioRespData;
    logic        ioRespError;
    logic        serialValid;
    logic [7:0]  serialData;
    logic        serialReady = 1'b0;
    logic        timerInterrupt;

    int n_vec = 0;
    int n_err = 0;

    mmio_responder #(
        .SERIAL_FIFO_DEPTH (DEPTH),
        .TIMER_PRESCALE    (PRESCALE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ioReqValid     (ioReqValid),
        .ioReqReady     (ioReqReady),
        .ioReqIsWrite   (ioReqIsWrite),
        .ioReqAddr      (ioReqAddr),
        .ioReqWriteData (ioReqWriteData),
        .ioRespValid    (ioRespValid),
        .ioRespData     (ioRespData),
        .ioRespError    (ioRespError),
        .serialValid    (serialValid),
        .serialData     (serialData),
        .serialReady    (serialReady),
        .timerInterrupt (timerInterrupt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [21:0] io_addr(input logic [19:0] off);
        return {1'b0, 1'b1, off};
    endfunction

    // ---------------- reference model ----------------
    longint unsigned m_mtime = 0;
    longint unsigned m_cmp   = '1;
    int unsigned     m_presc = 0;
    byte unsigned    m_fifo[$];
    logic            m_rv = 1'b0;
    logic [31:0]     m_rd = '0;
    logic            m_re = 1'b0;
    logic            m_irq = 1'b0;

    always @(posedge clk) begin
        longint unsigned old;
        logic            acc, deq;
        logic [19:0]     off;
        if (rst) begin
            m_mtime = 0;
            m_cmp   = '1;
            m_presc = 0;
            m_fifo.delete();
            m_rv = 1'b0; m_rd = '0; m_re = 1'b0; m_irq = 1'b0;
        end else begin
            acc = ioReqValid && (m_fifo.size() < DEPTH);
            deq = (m_fifo.size() != 0) && serialReady;
            old = m_mtime;
            if (m_presc == PRESCALE - 1) begin
                m_presc = 0;
                m_mtime = m_mtime + 1;
            end else begin
                m_presc++;
            end
            if (deq) void'(m_fifo.pop_front());
            m_rv = acc; m_rd = '0; m_re = 1'b0;
            if (acc) begin
                off = ioReqAddr[19:0];
                if (!ioReqAddr[20] || off[1:0] != 2'b00 ||
                    !(off inside {20'h0, 20'h4, 20'h8, 20'hC, 20'h2000})) begin
                    m_re = 1'b1;
                end else if (ioReqIsWrite) begin
                    case (off)
                        20'h0:   m_mtime = {old[63:32], ioReqWriteData};
                        20'h4:   m_mtime = {ioReqWriteData, old[31:0]};
                        20'h8:   m_cmp[31:0]  = ioReqWriteData;
                        20'hC:   m_cmp[63:32] = ioReqWriteData;
                        default: m_fifo.push_back(ioReqWriteData[7:0]);
                    endcase
                end else begin
                    case (off)
                        20'h0:   m_rd = old[31:0];
                        20'h4:   m_rd = old[63:32];
                        20'h8:   m_rd = m_cmp[31:0];
                        20'hC:   m_rd = m_cmp[63:32];
                        default: m_rd = '0;
                    endcase
                end
            end
            m_irq = (m_mtime >= m_cmp);
        end
        #2;
        chk("ready",      ioReqReady,     m_fifo.size() < DEPTH);
        chk("resp_valid", ioRespValid,    m_rv);
        chk("resp_data",  ioRespData,     m_rd);
        chk("resp_err",   ioRespError,    m_re);
        chk("ser_valid",  serialValid,    m_fifo.size() != 0);
        if (m_fifo.size() != 0) chk("ser_data", serialData, m_fifo[0]);
        chk("irq",        timerInterrupt, m_irq);
    end

    // ---------------- directed helpers (called at negedge) ----------------
    task automatic issue(input logic wr, input logic [21:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic re);
        int unsigned n = 0;
        ioReqValid = 1'b1; ioReqIsWrite = wr; ioReqAddr = a; ioReqWriteData = wd;
        while (!ioReqReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ioReqReady) begin
            chk("issue_ready_timeout", ioReqReady, 1);
            ioReqValid = 1'b0;
            rd = '0;
            re = 1'b1;
        end else begin
            @(negedge clk);
            ioReqValid = 1'b0;
            chk("issue_resp_valid", ioRespValid, 1);
            rd = ioRespData;
            re = ioRespError;
        end
    endtask

    task automatic rd_chk(input string name, input logic [19:0] off, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        issue(1'b0, io_addr(off), '0, d, e);
        chk(name, d, exp);
        chk({name, "_err"}, e, 0);
    endtask

    task automatic wr(input logic [19:0] off, input logic [31:0] wd);
        logic [31:0] d;
        logic        e;
        issue(1'b1, io_addr(off), wd, d, e);
        chk("wr_err", e, 0);
    endtask

    task automatic err_chk(input string name, input logic w, input logic [21:0] a);
        logic [31:0] d;
        logic        e;
        issue(w, a, 32'hDEAD_BEEF, d, e);
        chk({name, "_err"}, e, 1);
        chk({name, "_data"}, d, 0);
    endtask

    localparam logic [19:0] OFF_LIST [10] = '{20'h0, 20'h4, 20'h8, 20'hC, 20'h2000,
                                             20'h2000, 20'h10, 20'h1, 20'h2004, 20'h2002};

    initial begin
        int unsigned n;
        logic [19:0] off;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", ioReqReady, 1);
        chk("rst_resp_valid", ioRespValid, 0);
        chk("rst_ser_valid", serialValid, 0);
        chk("rst_irq", timerInterrupt, 0);
        rst = 1'b0;

        // Free-running count
        repeat (10) @(negedge clk);
        rd_chk("mtime_after_10", 20'h0, 32'h0000_000A);
        rd_chk("mtime_hi_after_10", 20'h4, 32'h0);
        chk("irq_idle", timerInterrupt, 0);

        // 32-bit carry into the upper half; write beats same-cycle increment
        wr(20'h0, 32'hFFFF_FFFF);
        wr(20'h4, 32'h0);
        @(negedge clk);
        rd_chk("carry_lo", 20'h0, 32'h0);
        rd_chk("carry_hi", 20'h4, 32'h1);
        wr(20'h0, 32'h1234_5678);
        rd_chk("write_persists", 20'h0, 32'h1234_5678);

        // Interrupt rise and drop
        wr(20'h4, 32'h0);
        wr(20'h0, 32'h18);
        wr(20'h8, 32'h20);
        wr(20'hC, 32'h0);
        chk("irq_before", timerInterrupt, 0);
        n = 0;
        while (!timerInterrupt && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("irq_rise", timerInterrupt, 1);
        rd_chk("mtime_at_irq", 20'h0, 32'h20);
        chk("irq_held", timerInterrupt, 1);
        wr(20'hC, 32'hFFFF_FFFF);
        chk("irq_drop", timerInterrupt, 0);

        // 64-bit wrap
        wr(20'h4, 32'hFFFF_FFFF);
        wr(20'h0, 32'hFFFF_FFFF);
        rd_chk("wrap_lo", 20'h0, 32'hFFFF_FFFF);
        rd_chk("wrap_hi", 20'h4, 32'h0);

        // Serial FIFO fill, stall, drain
        serialReady = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) wr(20'h2000, 32'hAB00 | (32'h41 + i));
        chk("full_ready", ioReqReady, 0);
        chk("full_head", serialData, 8'h41);
        ioReqValid = 1'b1; ioReqIsWrite = 1'b0; ioReqAddr = io_addr(20'h0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", ioReqReady, 0);
            chk("stall_resp", ioRespValid, 0);
        end
        serialReady = 1'b1;
        @(negedge clk);
        chk("drain_ready", ioReqReady, 1);
        chk("drain_resp0", ioRespValid, 0);
        chk("drain_b1", serialData, 8'h42);
        @(negedge clk);
        chk("stalled_load_resp", ioRespValid, 1);
        ioReqValid = 1'b0;
        chk("drain_b2", serialData, 8'h43);
        @(negedge clk);
        chk("drain_b3", serialData, 8'h44);
        @(negedge clk);
        chk("drain_empty", serialValid, 0);
        serialReady = 1'b0;

        // Error responses
        err_chk("bad_off", 1'b0, io_addr(20'h10));
        err_chk("misalign", 1'b0, io_addr(20'h1));
        err_chk("not_io_store", 1'b1, 22'h0);
        err_chk("not_io_serial", 1'b1, {2'b00, 20'h2000});
        chk("err_no_enqueue", serialValid, 0);
        rd_chk("serial_read", 20'h2000, 32'h0);

        // Reset with data queued and a request accepted in the reset cycle
        wr(20'h2000, 32'h61);
        wr(20'h2000, 32'h62);
        rst = 1'b1;
        ioReqValid = 1'b1; ioReqIsWrite = 1'b0; ioReqAddr = io_addr(20'h0);
        @(negedge clk);
        rst = 1'b0;
        ioReqValid = 1'b0;
        chk("midrst_ser_valid", serialValid, 0);
        chk("midrst_resp", ioRespValid, 0);
        chk("midrst_ready", ioReqReady, 1);
        rd_chk("midrst_mtime", 20'h0, 32'h0);

        // Random traffic against the model
        for (int unsigned c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            ioReqValid = $urandom_range(0, 1);
            ioReqIsWrite = $urandom_range(0, 1);
            off = OFF_LIST[$urandom_range(0, 9)];
            ioReqAddr = {1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), off};
            ioReqWriteData = $urandom;
            serialReady = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        ioReqValid = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
